seq_mem_stream_reader: RTL and testbench
========================================

SEQ_MEM_STREAM_READER -- requirements
Module: seq_mem_stream_reader

Interface
REQ-001 Parameter WIDTH, default 32, data word width; SHALL match the attached memory.
REQ-002 Parameter SIZE, default 4, number of memory words.
REQ-003 Parameter IDX_SIZE, default 4, address width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin a burst read.
REQ-007 base  input  IDX_SIZE  first address of the burst.
REQ-008 count  input  IDX_SIZE+1  number of words to read.
REQ-009 busy  output  1  high from the accepted start until the done cycle.
REQ-010 done  output  1  one-cycle pulse when the burst completes.
REQ-011 err  output  1  one-cycle pulse when start is rejected.
REQ-012 mem_addr0  output  IDX_SIZE  memory address.
REQ-013 mem_read_en  output  1  memory read strobe.
REQ-014 mem_out  input  WIDTH  memory read data.
REQ-015 mem_read_done  input  1  memory read-complete flag.
REQ-016 out_data  output  WIDTH  stream data.
REQ-017 out_valid  output  1  stream valid.
REQ-018 out_ready  input  1  stream ready; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-019 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-020 In IDLE, start with base<SIZE and count>0 SHALL latch the address and remaining count, then enter RUN next cycle.
REQ-021 In IDLE, start with count==0 and base<SIZE SHALL pulse done the next cycle, leave busy low, and remain in IDLE.
REQ-022 In IDLE, start with base>=SIZE SHALL pulse err the next cycle, issue no reads, and remain in IDLE.
REQ-023 start outside IDLE SHALL be ignored, with no err pulse.
REQ-024 The block SHALL have at most one read outstanding, with read_done expected one cycle after read_en.
REQ-025 Reads SHALL be buffered in a 2-entry FIFO.
REQ-026 In RUN, mem_read_en SHALL assert only when FIFO occupancy plus outstanding reads is less than 2.
REQ-027 Each issued read SHALL increment the address, wrapping from SIZE-1 to 0, and decrement the remaining count.
REQ-028 mem_out SHALL be pushed into the FIFO only on cycles where mem_read_done is high and a read is outstanding; any other mem_read_done SHALL be ignored.
REQ-029 out_valid SHALL equal FIFO not-empty, and out_data SHALL be the FIFO head, held stable while out_valid is high and out_ready is low.
REQ-030 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-031 The FIFO SHALL never overflow.
REQ-032 When the last read is issued, the state SHALL move RUN to DRAIN.
REQ-033 In DRAIN, when the FIFO is empty and no read is outstanding, done SHALL pulse, busy SHALL drop in the same cycle, and the state SHALL return to IDLE.
REQ-034 With out_ready held high, latency from an accepted start to the first out_valid SHALL be 3 cycles.
REQ-035 With out_ready held high, sustained throughput SHALL be one word every cycle.
REQ-036 Words SHALL be delivered in address order, with no loss or duplication.

Reset
REQ-037 Assertion of reset_n SHALL immediately force IDLE, empty the FIFO, and clear the outstanding-read flag and the address and count registers.
REQ-038 During reset, outputs SHALL be busy=0, done=0, err=0, mem_read_en=0, mem_addr0=0, out_valid=0 and out_data=0.
REQ-039 A mem_read_done arriving after reset SHALL be ignored.
REQ-040 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-041 With macro SEQ_MEM_STREAM_READER_ABORT_EN defined, the block SHALL have an input port abort (1 bit).
REQ-042 With the macro defined, abort high in RUN or DRAIN SHALL stop issuing reads, flush the FIFO, and discard any outstanding read data.
REQ-043 With the macro defined, an abort SHALL pulse done on the next cycle and return the block to IDLE.
REQ-044 With the macro defined, abort in IDLE SHALL have no effect.
REQ-045 Without the macro, the abort port SHALL be absent and behaviour SHALL be as REQ-019 to REQ-036.

Verification
REQ-046 Memory holds {A,B,C,D}; start base=0 count=4; out_ready=1 -> out_valid from cycle 3; A,B,C,D on consecutive cycles; done one cycle after D; busy high for 6 cycles.
REQ-047 Start base=3 count=3 -> addresses 3,0,1; output D,A,B.
REQ-048 Start base=0 count=4; out_ready=0 for 10 cycles, then 1 -> at most 2 reads issued while stalled; A held stable; all four words delivered exactly once, then done.
REQ-049 Start count=0 -> done next cycle, no mem_read_en; start base=5 -> err next cycle, no reads; start during RUN -> ignored.
REQ-050 Assert reset_n low while a read is outstanding in RUN -> all outputs 0 immediately; the stray mem_read_done is ignored; a new start base=1 count=1 returns B.
REQ-051 With SEQ_MEM_STREAM_READER_ABORT_EN defined, abort after 2 words with FIFO full -> out_valid 0 next cycle, done pulses, no further reads.

Source files
------------

// File: rtl/seq_mem_stream_reader.sv
// seq_mem_stream_reader: burst reader from a single-port memory into a valid/ready stream
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, base, count           burst request: first address and number of words
//   abort                        burst abort (only with SEQ_MEM_STREAM_READER_ABORT_EN defined)
//   busy, done, err              status: burst active, completion pulse, rejected-start pulse
//   mem_addr0, mem_read_en       memory read request
//   mem_out, mem_read_done       memory read response (one cycle after mem_read_en)
//   out_data, out_valid, out_ready  output stream
module seq_mem_stream_reader #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 4,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [IDX_SIZE:0]   count,
`ifdef SEQ_MEM_STREAM_READER_ABORT_EN
  input  logic                abort,
`endif
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic                mem_read_en,
  input  logic [WIDTH-1:0]    mem_out,
  input  logic                mem_read_done,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [IDX_SIZE-1:0] LAST = IDX_SIZE'(SIZE - 1);
  state_t              state_q, state_d;
  logic [IDX_SIZE-1:0] addr_q, addr_d;
  logic [IDX_SIZE:0]   rem_q, rem_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                rd_q, wr_q;
  logic [WIDTH-1:0]    fifo_q [2];
  logic                abort_w, push, pop, issue, base_ok;
  logic [1:0]          occ_n;
`ifdef SEQ_MEM_STREAM_READER_ABORT_EN
  assign abort_w = abort && (state_q != IDLE);
`else
  assign abort_w = 1'b0;
`endif
  // Only a response to our own outstanding read is accepted.
  assign push    = pend_q && mem_read_done;
  assign pop     = out_valid && out_ready;
  assign base_ok = {1'b0, base} < (IDX_SIZE+1)'(SIZE);
  // Occupancy at the end of this cycle; the outstanding read lands in it
  // this cycle, so a new read may go out whenever this stays below 2.
  assign occ_n   = cnt_q + {1'b0, push} - {1'b0, pop};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (!base_ok) err_d = 1'b1;
        else if (count == '0) done_d = 1'b1;
        else begin
          addr_d  = base;
          rem_d   = count;
          state_d = RUN;
        end
      end
      RUN: if (issue) begin
        addr_d = (addr_q == LAST) ? '0 : addr_q + IDX_SIZE'(1);
        rem_d  = rem_q - (IDX_SIZE+1)'(1);
        if (rem_q == (IDX_SIZE+1)'(1)) state_d = DRAIN;
      end
      DRAIN: if (cnt_d == '0 && !pend_d) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort_w) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_comb begin
    issue       = (state_q == RUN) && !abort_w && (!pend_q || mem_read_done) && (occ_n < 2'd2);
    busy        = state_q != IDLE;
    mem_read_en = issue;
    mem_addr0   = addr_q;
    out_valid   = cnt_q != '0;
    out_data    = fifo_q[rd_q];
    done        = done_q;
    err         = err_q;
  end
  assign cnt_d  = abort_w ? '0 : occ_n;
  assign pend_d = !abort_w && (issue || (pend_q && !mem_read_done));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      rem_q     <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      pend_q <= pend_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      if (abort_w) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[wr_q] <= mem_out;
          wr_q         <= ~wr_q;
        end
        if (pop) rd_q <= ~rd_q;
      end
    end
  end
endmodule

// File: tb/tb_seq_mem_stream_reader.sv
// tb_seq_mem_stream_reader: vector table, random bursts vs. reference model, and corner sequences
module tb_seq_mem_stream_reader;
  logic        clk = 1'b0;
  logic        reset_n, start, out_ready, stray_en;
  logic [3:0]  base;
  logic [4:0]  count;
  logic        busy, done, err, mem_read_en, mem_read_done, out_valid;
  logic [3:0]  mem_addr0;
  logic [31:0] mem_out, out_data;
  logic [31:0] memw [4];
  logic        rd_done_q = 1'b0, stray = 1'b0;
  logic [31:0] rdata_q = '0;
`ifdef SEQ_MEM_STREAM_READER_ABORT_EN
  logic        abort;
`endif
  int n_cmp = 0, n_bad = 0;
  seq_mem_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base(base), .count(count),
`ifdef SEQ_MEM_STREAM_READER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .err(err), .mem_addr0(mem_addr0), .mem_read_en(mem_read_en),
    .mem_out(mem_out), .mem_read_done(mem_read_done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rd_done_q <= mem_read_en;
    rdata_q   <= memw[mem_addr0[1:0]];
    stray     <= stray_en && ($urandom_range(0, 3) == 0);
  end
  assign mem_read_done = rd_done_q | stray;
  assign mem_out       = rdata_q;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic rdy(input int mode, input int k);
    return (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k > 10);
  endfunction
  logic [31:0] got[$];
  int n_reads, first_v, last_v, done_c, busy_n, max_infl, stable_bad, ovl_bad, stall_reads, post_bad;
  bit saw_err, saw_done, tmo;
  // Entered just after a rising edge; returns just after a rising edge.
  task automatic run_burst(input logic [3:0] b, input logic [4:0] c, input int mode, input bit noise);
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;
    int dl = 0;
    got.delete();
    {n_reads, busy_n, max_infl, stable_bad, ovl_bad, stall_reads, post_bad} = '0;
    {first_v, last_v, done_c} = {-1, -1, -1};
    {saw_err, saw_done, tmo} = '0;
    base = b; count = c; start = 1'b1; out_ready = rdy(mode, 0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (mem_read_en) begin
        n_reads++;
        if (mode == 2 && k <= 10) stall_reads++;
      end
      if (busy) busy_n++;
      if (out_valid && first_v < 0) first_v = k;
      if (pv && !pr && (!out_valid || out_data !== pd)) stable_bad++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_v = k;
        dl++;
      end
      if (n_reads - dl > max_infl) max_infl = n_reads - dl;
      if (done && busy) ovl_bad++;
      if (err) saw_err = 1'b1;
      if (done) begin
        saw_done = 1'b1;
        done_c = k;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      @(posedge clk); #1;
      start = noise && k == 1;
      if (noise && k == 1) begin
        base = 4'd7;
        count = 5'd1;
      end
      out_ready = rdy(mode, k + 1);
      if (saw_done || saw_err) break;
    end
    if (!(saw_done || saw_err)) tmo = 1'b1;
    @(negedge clk);
    if (done || err || busy || out_valid) post_bad++;
    @(posedge clk); #1;
  endtask
  task automatic check_burst(input logic [3:0] b, input logic [4:0] c, input int mode, input bit noise);
    logic [31:0] exp[$];
    bit e = b >= 4;
    string t = $sformatf("b%0d_c%0d_m%0d", b, c, mode);
    if (!e) for (int i = 0; i < c; i++) exp.push_back(memw[(b + i) % 4]);
    run_burst(b, c, mode, noise);
    chk({t, " timeout"}, tmo, 0);
    chk({t, " err"}, saw_err, e);
    chk({t, " done"}, saw_done, !e);
    chk({t, " nwords"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk($sformatf("%s word%0d", t, i), got[i], exp[i]);
    chk({t, " reads"}, n_reads, exp.size());
    chk({t, " stable"}, stable_bad, 0);
    chk({t, " done_busy_overlap"}, ovl_bad, 0);
    chk({t, " inflight_le2"}, max_infl <= 2, 1);
    chk({t, " post_idle"}, post_bad, 0);
    if (exp.size() == 0) chk({t, " busy_never"}, busy_n, 0);
    if (mode == 2) chk({t, " stall_reads_le2"}, stall_reads <= 2, 1);
  endtask
  typedef struct {
    logic [3:0] b;
    logic [4:0] c;
    int         mode;
    bit         exp_err;
    int         exp_n;
  } vec_t;
  vec_t tbl[11];
  initial begin
    reset_n = 1'b0; start = 1'b0; base = '0; count = '0; out_ready = 1'b0; stray_en = 1'b0;
`ifdef SEQ_MEM_STREAM_READER_ABORT_EN
    abort = 1'b0;
`endif
    memw[0] = 32'hAAAA_0000; memw[1] = 32'hBBBB_1111; memw[2] = 32'hCCCC_2222; memw[3] = 32'hDDDD_3333;
    tbl[0]  = '{4'd0, 5'd4, 0, 1'b0, 4};
    tbl[1]  = '{4'd3, 5'd3, 0, 1'b0, 3};
    tbl[2]  = '{4'd0, 5'd0, 0, 1'b0, 0};
    tbl[3]  = '{4'd5, 5'd2, 0, 1'b1, 0};
    tbl[4]  = '{4'd15, 5'd0, 0, 1'b1, 0};
    tbl[5]  = '{4'd2, 5'd1, 0, 1'b0, 1};
    tbl[6]  = '{4'd1, 5'd16, 1, 1'b0, 16};
    tbl[7]  = '{4'd3, 5'd7, 1, 1'b0, 7};
    tbl[8]  = '{4'd0, 5'd4, 2, 1'b0, 4};
    tbl[9]  = '{4'd4, 5'd1, 0, 1'b1, 0};
    tbl[10] = '{4'd3, 5'd31, 1, 1'b0, 31};
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0); chk("rst done", done, 0); chk("rst err", err, 0);
    chk("rst read_en", mem_read_en, 0); chk("rst addr", mem_addr0, 0);
    chk("rst valid", out_valid, 0); chk("rst data", out_data, 0);
    reset_n = 1'b1;
    foreach (tbl[i]) begin
      check_burst(tbl[i].b, tbl[i].c, tbl[i].mode, 1'b0);
      chk($sformatf("tbl%0d err", i), saw_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d n", i), got.size(), tbl[i].exp_n);
    end
    check_burst(4'd0, 5'd4, 0, 1'b0);
    chk("lat first_valid", first_v, 3);
    chk("lat last_valid", last_v, 6);
    chk("lat done", done_c, 7);
    chk("lat busy_cycles", busy_n, 6);
    check_burst(4'd0, 5'd4, 0, 1'b1);
    stray_en = 1'b1;
    for (int r = 0; r < 40; r++)
      check_burst(4'($urandom_range(0, 5)), 5'($urandom_range(0, 12)), $urandom_range(0, 2), 1'b0);
    base = 4'd0; count = 5'd4; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("arst busy", busy, 0); chk("arst done", done, 0); chk("arst err", err, 0);
    chk("arst read_en", mem_read_en, 0); chk("arst addr", mem_addr0, 0);
    chk("arst valid", out_valid, 0); chk("arst data", out_data, 0);
    #1;
    reset_n = 1'b1;
    stray_en = 1'b0;
    check_burst(4'd1, 5'd1, 0, 1'b0);
    chk("arst after word", got.size() > 0 ? got[0] : 32'hX, memw[1]);
`ifdef SEQ_MEM_STREAM_READER_ABORT_EN
    base = 4'd0; count = 5'd4; start = 1'b1; out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    chk("abort full valid", out_valid, 1);
    chk("abort read_en", mem_read_en, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort valid_gone", out_valid, 0);
    chk("abort done", done, 1);
    chk("abort busy", busy, 0);
    n_reads = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_read_en || out_valid) n_reads++;
    end
    chk("abort quiet", n_reads, 0);
    @(posedge clk); #1;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
